// File: rtl/sp_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_responder
// Brief    : Valid/ready front end for a DEPTH x DATA_WIDTH synchronous
//            single-port RAM. Writes are absorbed silently. Reads return
//            in order through a small response FIFO. Credits keep every
//            accepted read guaranteed a FIFO slot.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Credit limit, one bit wider than the FIFO count so count + pend fits.
  localparam logic [CNT_W:0] RSP_LIMIT = RSP_DEPTH[CNT_W:0];

  // Storage array and its read register; neither is reset so the array
  // can map onto a block RAM and its contents survive rst.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;

  logic                  pend_q,     pend_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [15:0]           rd_count_q, rd_count_d;

  logic [CNT_W:0]        credits_used;
  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  push;
  logic                  pop;

  // A read in the pend stage already owns a FIFO slot, so it counts
  // against the credit limit alongside the buffered responses.
  assign credits_used = {1'b0, count_q} + (CNT_W + 1)'(pend_q);
  assign req_ready    = credits_used < RSP_LIMIT;

  // No accept while rst is high: the array has no reset, so a request
  // held during reset must not corrupt it.
  assign req_fire = req_valid && req_ready && !rst;
  assign wr_fire  = req_fire && req_we;
  assign rd_fire  = req_fire && !req_we;

  assign push      = pend_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

  // Synchronous single-port array: write on write accept, registered read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[req_addr] <= req_wdata;
    end
    if (rd_fire) begin
      mem_rdata_q <= mem[req_addr];
    end
  end

  // Next-state for pend stage, response FIFO and accept counters.
  always_comb begin
    pend_d     = rd_fire;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_fire) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (rd_fire) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  // State registers with asynchronous reset; FIFO storage is cleared so
  // rsp_rdata reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_responder
// Brief    : Directed bench for sp_ram_responder with a transaction-level
//            reference model (word array + queue of outstanding reads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_responder;

  localparam int DW        = 32;
  localparam int AW        = 10;
  localparam int RSP_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  sp_ram_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: memory contents, outstanding reads in accept order
  // (each becomes visible one edge after it is accepted), accept counters.
  // Every accepted read holds one credit until it is popped.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    bit            known;
    int            avail;
  } rsp_t;

  logic [DW-1:0] mm [2**AW];
  bit            mk [2**AW];
  rsp_t          q [$];
  logic [15:0]   m_wr = '0;
  logic [15:0]   m_rd = '0;
  int            cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit   v_before;
    bit   rdy_before;
    rsp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      m_wr = '0;
      m_rd = '0;
      return;
    end
    v_before   = (q.size() > 0) && (q[0].avail <= cyc - 1);
    rdy_before = (q.size() < RSP_DEPTH);
    if (v_before && rsp_ready) void'(q.pop_front());
    if (req_valid && rdy_before) begin
      if (req_we) begin
        mm[req_addr] = req_wdata;
        mk[req_addr] = 1'b1;
        m_wr++;
      end else begin
        e.data  = mm[req_addr];
        e.known = mk[req_addr];
        e.avail = cyc + 1;
        q.push_back(e);
        m_rd++;
      end
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (q.size() > 0) && (q[0].avail <= cyc);
    chk("req_ready", 32'(req_ready), 32'(q.size() < RSP_DEPTH));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev && q[0].known) chk("rsp_rdata", rsp_rdata, q[0].data);
    if (rst) chk("rsp_rdata_in_reset", rsp_rdata, 32'h0);
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("rd_count", 32'(rd_count), 32'(m_rd));
  endtask

  // Compare process: advance model on each edge, check mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
      if (rst) begin
        q.delete();
        m_wr = '0;
        m_rd = '0;
      end
      compare();
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: all start and end on a falling edge.
  // ---------------------------------------------------------------------
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waited);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: req_ready stayed %b, required 1 within 50 cycles", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d, output int lat);
    lat = 0;
    while (!(rsp_valid && rsp_ready) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!(rsp_valid && rsp_ready)) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid stayed %b, required 1 within 50 cycles", rsp_valid);
    end
    d = rsp_rdata;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    logic [DW-1:0] d;
    int            w;
    int            lat;
    int            nacc;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset with a live write request must not touch the array.
    do_req(1'b1, 10'd7, 32'h1234_5678, w);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd7;
    req_wdata = 32'hAAAA_5555;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    do_req(1'b0, 10'd7, '0, w);
    wait_rsp(d, lat);
    chk("rst_no_write", d, 32'h1234_5678);

    // Fill 0..31 then read back-to-back.
    reset_pulse();
    for (int i = 0; i < 32; i++) do_req(1'b1, 10'(i), $urandom, w);
    for (int i = 0; i < 32; i++) do_req(1'b0, 10'(i), '0, w);
    repeat (4) @(negedge clk);
    chk("fill_wr_count", 32'(wr_count), 32'd32);
    chk("fill_rd_count", 32'(rd_count), 32'd32);

    // Backpressure: exactly RSP_DEPTH reads accepted while rsp_ready low.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 10'(i), '0, w);
      chk("bp_accept_wait", 32'(w), 32'd0);
    end
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd4;
    nacc      = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready) nacc++;
    end
    chk("bp_hold_accepts", 32'(nacc), 32'd0);
    chk("bp_rdata_stable", rsp_rdata, mm[0]);
    rsp_ready = 1'b1;
    do_req(1'b0, 10'd4, '0, w);
    chk("bp_resume_wait", 32'(w), 32'd1);
    for (int i = 5; i < 8; i++) do_req(1'b0, 10'(i), '0, w);
    repeat (8) @(negedge clk);
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // Read-after-write, response one cycle after the read is taken.
    do_req(1'b1, 10'd5, 32'hDEAD_BEEF, w);
    do_req(1'b0, 10'd5, '0, w);
    wait_rsp(d, lat);
    chk("raw_data", d, 32'hDEAD_BEEF);
    chk("raw_latency", 32'(lat), 32'd1);

    // Reset with three reads outstanding.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 10'(i), '0, w);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    do_req(1'b0, 10'd5, '0, w);
    wait_rsp(d, lat);
    chk("midrst_first_rsp", d, 32'hDEAD_BEEF);
    chk("midrst_latency", 32'(lat), 32'd1);

    // Top address.
    do_req(1'b1, 10'd1023, 32'h0000_0001, w);
    do_req(1'b0, 10'd1023, '0, w);
    wait_rsp(d, lat);
    chk("top_addr_data", d, 32'h0000_0001);

    // Write counter wrap.
    reset_pulse();
    for (int i = 0; i < 65535; i++) do_req(1'b1, 10'(i), 32'(i), w);
    chk("wr_count_ffff", 32'(wr_count), 32'h0000_FFFF);
    do_req(1'b1, 10'd0, 32'h0, w);
    chk("wr_count_wrap", 32'(wr_count), 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
